// File: rtl/hist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hist_pkg
//  Description : Shared state encoding, parameter defaults and bar helpers
//                for the histogram peak-hold engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package hist_pkg;

    localparam int SAMPLES_DEF    = 16;
    localparam int MAG_W_DEF      = 18;
    localparam int SHIFT_DEF      = 13;
    localparam int MAX_HEIGHT_DEF = 24;
    localparam int HEIGHT_W_DEF   = 5;
    localparam int HOLD_TICKS_DEF = 4;
    localparam int DECAY_STEP_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DECAY = 2'd2
    } state_e;

    // Extracts one bar from the packed bar_height bus.
    function automatic logic [HEIGHT_W_DEF-1:0] bar_of(
        input logic [SAMPLES_DEF*HEIGHT_W_DEF-1:0] bars,
        input int unsigned                         idx
    );
        return bars[idx*HEIGHT_W_DEF +: HEIGHT_W_DEF];
    endfunction

endpackage
`default_nettype wire

// File: rtl/hist_peak_hold_if.sv
`default_nettype none
// ============================================================================
//  Module      : hist_peak_hold_if
//  Description : Frame/tick inputs and bar/peak outputs of the engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hist_peak_hold_if #(
    parameter int SAMPLES  = 16,
    parameter int MAG_W    = 18,
    parameter int HEIGHT_W = 5,
    parameter int IDX_W    = $clog2(SAMPLES)
);
    logic                         done;
    logic [SAMPLES*MAG_W-1:0]     magnitudes;
    logic                         tick;
    logic [SAMPLES*HEIGHT_W-1:0]  bar_height;
    logic [IDX_W-1:0]             peak_index;
    logic [HEIGHT_W-1:0]          peak_height;
    logic                         update_valid;
    logic                         busy;
    logic [7:0]                   overrun_count;

    modport master (
        output done, magnitudes, tick,
        input  bar_height, peak_index, peak_height, update_valid, busy, overrun_count
    );

    modport slave (
        input  done, magnitudes, tick,
        output bar_height, peak_index, peak_height, update_valid, busy, overrun_count
    );
endinterface
`default_nettype wire

// File: rtl/hist_bin_scaler.sv
`default_nettype none
// ============================================================================
//  Module      : hist_bin_scaler
//  Description : Magnitude to bar height: right shift then saturate.
//  Revision    : 1.0 - initial release
// ============================================================================
module hist_bin_scaler #(
    parameter int MAG_W      = 18,
    parameter int SHIFT      = 13,
    parameter int MAX_HEIGHT = 24,
    parameter int HEIGHT_W   = 5
) (
    input  logic [MAG_W-1:0]    mag_i,
    output logic [HEIGHT_W-1:0] height_o
);
    localparam logic [MAG_W-1:0]    MAX_M = MAG_W'(MAX_HEIGHT);
    localparam logic [HEIGHT_W-1:0] MAX_H = HEIGHT_W'(MAX_HEIGHT);

    logic [MAG_W-1:0] w_shift;

    assign w_shift  = mag_i >> SHIFT;
    assign height_o = (w_shift > MAX_M) ? MAX_H : w_shift[HEIGHT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/hist_peak_hold.sv
`default_nettype none
// ============================================================================
//  Module      : hist_peak_hold
//  Description : Serial per-bin bar height engine with peak hold, timed
//                decay and tallest-bar tracking.
//  Revision    : 1.0 - initial release
// ============================================================================
module hist_peak_hold
    import hist_pkg::*;
#(
    parameter int SAMPLES    = SAMPLES_DEF,
    parameter int MAG_W      = MAG_W_DEF,
    parameter int SHIFT      = SHIFT_DEF,
    parameter int MAX_HEIGHT = MAX_HEIGHT_DEF,
    parameter int HEIGHT_W   = HEIGHT_W_DEF,
    parameter int HOLD_TICKS = HOLD_TICKS_DEF,
    parameter int DECAY_STEP = DECAY_STEP_DEF
) (
    input  logic            clk,
    input  logic            reset,
    hist_peak_hold_if.slave bus
);
    localparam int IDX_W  = $clog2(SAMPLES);
    localparam int CNT_W  = IDX_W + 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [CNT_W-1:0] EXIT_CNT = CNT_W'(SAMPLES);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          bin_q, bin_d;
    logic [MAG_W-1:0]          snap_q [SAMPLES];
    logic [MAG_W-1:0]          pend_q [SAMPLES];
    logic                      pend_frame_q;
    logic                      pend_tick_q;
    logic [HEIGHT_W-1:0]       held_q [SAMPLES];
    logic [HEIGHT_W-1:0]       held_d [SAMPLES];
    logic [HOLD_W-1:0]         hold_q [SAMPLES];
    logic [HOLD_W-1:0]         hold_d [SAMPLES];
    logic [HEIGHT_W-1:0]       run_max_q, run_max_d;
    logic [IDX_W-1:0]          run_idx_q, run_idx_d;
    logic [SAMPLES*HEIGHT_W-1:0] bar_q;
    logic [IDX_W-1:0]          peak_idx_q;
    logic [HEIGHT_W-1:0]       peak_h_q;
    logic                      uv_q;
    logic [7:0]                ovr_q;

    logic [IDX_W-1:0]          w_bin;
    logic                      w_exit;
    logic [HEIGHT_W-1:0]       w_scaled;
    logic [HEIGHT_W-1:0]       w_cur_held;
    logic [HEIGHT_W-1:0]       w_new_held;
    logic [HOLD_W-1:0]         w_new_hold;

    assign w_bin  = bin_q[IDX_W-1:0];
    assign w_exit = (bin_q == EXIT_CNT);

    hist_bin_scaler #(
        .MAG_W      (MAG_W),
        .SHIFT      (SHIFT),
        .MAX_HEIGHT (MAX_HEIGHT),
        .HEIGHT_W   (HEIGHT_W)
    ) u_scaler (
        .mag_i    (snap_q[w_bin]),
        .height_o (w_scaled)
    );

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        held_d     = held_q;
        hold_d     = hold_q;
        run_max_d  = run_max_q;
        run_idx_d  = run_idx_q;
        w_cur_held = held_q[w_bin];
        w_new_held = w_cur_held;
        w_new_hold = hold_q[w_bin];

        case (state_q)
            ST_IDLE: begin
                bin_d = '0;
                if (bus.done || pend_frame_q) begin
                    state_d = ST_SCAN;
                end else if (bus.tick || pend_tick_q) begin
                    state_d = ST_DECAY;
                end
            end
            ST_SCAN: begin
                if (w_scaled >= w_cur_held) begin
                    w_new_held = w_scaled;
                    w_new_hold = HOLD_W'(HOLD_TICKS);
                end
            end
            ST_DECAY: begin
                if (hold_q[w_bin] != '0) begin
                    w_new_hold = hold_q[w_bin] - 1'b1;
                end else if (w_cur_held > HEIGHT_W'(DECAY_STEP)) begin
                    w_new_held = w_cur_held - HEIGHT_W'(DECAY_STEP);
                end else begin
                    w_new_held = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Extra cycle after the last bin publishes the finished results.
        if (state_q != ST_IDLE) begin
            if (w_exit) begin
                state_d = ST_IDLE;
            end else begin
                held_d[w_bin] = w_new_held;
                hold_d[w_bin] = w_new_hold;
                if (w_bin == '0 || w_new_held > run_max_q) begin
                    run_max_d = w_new_held;
                    run_idx_d = w_bin;
                end
                bin_d = bin_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bin_q        <= '0;
            run_max_q    <= '0;
            run_idx_q    <= '0;
            pend_frame_q <= 1'b0;
            pend_tick_q  <= 1'b0;
            bar_q        <= '0;
            peak_idx_q   <= '0;
            peak_h_q     <= '0;
            uv_q         <= 1'b0;
            ovr_q        <= '0;
            for (int i = 0; i < SAMPLES; i++) begin
                held_q[i] <= '0;
                hold_q[i] <= '0;
                snap_q[i] <= '0;
                pend_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            held_q    <= held_d;
            hold_q    <= hold_d;
            run_max_q <= run_max_d;
            run_idx_q <= run_idx_d;
            uv_q      <= 1'b0;

            // A frame already waiting is displaced by a newer one.
            if (bus.done && pend_frame_q && ovr_q != 8'hFF) begin
                ovr_q <= ovr_q + 8'd1;
            end

            if (state_q == ST_IDLE) begin
                if (bus.done || pend_frame_q) begin
                    for (int i = 0; i < SAMPLES; i++) begin
                        snap_q[i] <= bus.done ? bus.magnitudes[i*MAG_W +: MAG_W] : pend_q[i];
                    end
                    pend_frame_q <= 1'b0;
                    if (bus.tick) begin
                        pend_tick_q <= 1'b1;
                    end
                end else if (bus.tick || pend_tick_q) begin
                    pend_tick_q <= 1'b0;
                end
            end else begin
                if (bus.done) begin
                    for (int i = 0; i < SAMPLES; i++) begin
                        pend_q[i] <= bus.magnitudes[i*MAG_W +: MAG_W];
                    end
                    pend_frame_q <= 1'b1;
                end
                if (bus.tick) begin
                    pend_tick_q <= 1'b1;
                end
                if (w_exit) begin
                    for (int i = 0; i < SAMPLES; i++) begin
                        bar_q[i*HEIGHT_W +: HEIGHT_W] <= held_q[i];
                    end
                    peak_idx_q <= run_idx_q;
                    peak_h_q   <= run_max_q;
                    uv_q       <= 1'b1;
                end
            end
        end
    end

    assign bus.bar_height    = bar_q;
    assign bus.peak_index    = peak_idx_q;
    assign bus.peak_height   = peak_h_q;
    assign bus.update_valid  = uv_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.overrun_count = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_hist_peak_hold.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hist_peak_hold
//  Description : Directed self-checking bench for hist_peak_hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hist_peak_hold;
    import hist_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hist_peak_hold_if bus_if ();

    hist_peak_hold dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_uv(input int limit, output int n);
        n = 0;
        while (bus_if.update_valid !== 1'b1 && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus_if.bar_height !== '0) begin errors++; $display("FAIL reset_bars got=%h exp=0", bus_if.bar_height); end
        checks++; if (bus_if.peak_index !== 4'd0) begin errors++; $display("FAIL reset_pidx got=%0d exp=0", bus_if.peak_index); end
        checks++; if (bus_if.peak_height !== 5'd0) begin errors++; $display("FAIL reset_ph got=%0d exp=0", bus_if.peak_height); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
        checks++; if (bus_if.overrun_count !== 8'd0) begin errors++; $display("FAIL reset_ovr got=%0d exp=0", bus_if.overrun_count); end
        checks++; if (bus_if.update_valid !== 1'b0) begin errors++; $display("FAIL reset_uv got=%b exp=0", bus_if.update_valid); end
    endtask

    task automatic test_single_bin();
        logic [SAMPLES_DEF*MAG_W_DEF-1:0] m;
        int early;
        logic busy_seen;
        m = '0;
        m[3*MAG_W_DEF +: MAG_W_DEF] = 18'(5 << 13);
        bus_if.magnitudes = m;
        bus_if.done = 1'b1;
        step();
        bus_if.done = 1'b0;
        busy_seen = bus_if.busy;
        early = 0;
        for (int k = 1; k <= 17; k++) begin
            step();
            if (k < 17 && bus_if.update_valid === 1'b1) early++;
        end
        checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL scan_busy got=%b exp=1", busy_seen); end
        checks++; if (early !== 0) begin errors++; $display("FAIL scan_early_uv got=%0d exp=0", early); end
        checks++; if (bus_if.update_valid !== 1'b1) begin errors++; $display("FAIL scan_uv_at17 got=%b exp=1", bus_if.update_valid); end
        checks++; if (bus_if.bar_height !== {75'd0, 5'd5, 15'd0}) begin errors++; $display("FAIL scan_bars got=%h exp=%h", bus_if.bar_height, {75'd0, 5'd5, 15'd0}); end
        checks++; if (bus_if.peak_index !== 4'd3) begin errors++; $display("FAIL scan_pidx got=%0d exp=3", bus_if.peak_index); end
        checks++; if (bus_if.peak_height !== 5'd5) begin errors++; $display("FAIL scan_ph got=%0d exp=5", bus_if.peak_height); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL scan_idle got=%b exp=0", bus_if.busy); end
        step();
        checks++; if (bus_if.update_valid !== 1'b0) begin errors++; $display("FAIL scan_uv_pulse got=%b exp=0", bus_if.update_valid); end
    endtask

    task automatic test_decay();
        int n;
        int exp_h;
        for (int t = 1; t <= 10; t++) begin
            bus_if.tick = 1'b1;
            step();
            bus_if.tick = 1'b0;
            wait_uv(40, n);
            exp_h = (t <= 4) ? 5 : ((9 - t) > 0 ? 9 - t : 0);
            checks++; if (bus_if.update_valid !== 1'b1) begin errors++; $display("FAIL decay_timeout tick=%0d got=%b exp=1", t, bus_if.update_valid); end
            checks++; if (bar_of(bus_if.bar_height, 3) !== 5'(exp_h)) begin errors++; $display("FAIL decay_h3 tick=%0d got=%0d exp=%0d", t, bar_of(bus_if.bar_height, 3), exp_h); end
            if (t == 5) begin
                checks++; if (bus_if.peak_index !== 4'd3 || bus_if.peak_height !== 5'd4) begin errors++; $display("FAIL decay_peak got=%0d/%0d exp=3/4", bus_if.peak_index, bus_if.peak_height); end
            end
            step();
        end
    endtask

    task automatic test_saturate();
        int n;
        bus_if.magnitudes = {SAMPLES_DEF{18'h3FFFF}};
        bus_if.done = 1'b1;
        step();
        bus_if.done = 1'b0;
        wait_uv(40, n);
        checks++; if (bus_if.bar_height !== {SAMPLES_DEF{5'd24}}) begin errors++; $display("FAIL sat_bars got=%h exp=%h", bus_if.bar_height, {SAMPLES_DEF{5'd24}}); end
        checks++; if (bus_if.peak_index !== 4'd0 || bus_if.peak_height !== 5'd24) begin errors++; $display("FAIL sat_peak got=%0d/%0d exp=0/24", bus_if.peak_index, bus_if.peak_height); end
        step();
    endtask

    task automatic test_overrun();
        logic [SAMPLES_DEF*MAG_W_DEF-1:0] m;
        int pulses;
        logic [4:0] first_b1, first_b5;
        do_reset();
        m = '0; m[1*MAG_W_DEF +: MAG_W_DEF] = 18'(3 << 13);
        bus_if.magnitudes = m; bus_if.done = 1'b1; step(); bus_if.done = 1'b0;
        step(); step();
        m = '0; m[2*MAG_W_DEF +: MAG_W_DEF] = 18'(7 << 13);
        bus_if.magnitudes = m; bus_if.done = 1'b1; step(); bus_if.done = 1'b0;
        step();
        m = '0; m[4*MAG_W_DEF +: MAG_W_DEF] = 18'(2 << 13); m[5*MAG_W_DEF +: MAG_W_DEF] = 18'(9 << 13);
        bus_if.magnitudes = m; bus_if.done = 1'b1; step(); bus_if.done = 1'b0;
        pulses = 0; first_b1 = '0; first_b5 = '1;
        for (int k = 0; k < 60; k++) begin
            if (bus_if.update_valid === 1'b1) begin
                if (pulses == 0) begin first_b1 = bar_of(bus_if.bar_height, 1); first_b5 = bar_of(bus_if.bar_height, 5); end
                pulses++;
            end
            step();
        end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL ovr_pulses got=%0d exp=2", pulses); end
        checks++; if (first_b1 !== 5'd3 || first_b5 !== 5'd0) begin errors++; $display("FAIL ovr_first got=%0d/%0d exp=3/0", first_b1, first_b5); end
        checks++; if (bus_if.overrun_count !== 8'd1) begin errors++; $display("FAIL ovr_count got=%0d exp=1", bus_if.overrun_count); end
        checks++; if (bar_of(bus_if.bar_height, 2) !== 5'd0) begin errors++; $display("FAIL ovr_dropped_b2 got=%0d exp=0", bar_of(bus_if.bar_height, 2)); end
        checks++; if (bar_of(bus_if.bar_height, 4) !== 5'd2 || bar_of(bus_if.bar_height, 5) !== 5'd9) begin errors++; $display("FAIL ovr_third got=%0d/%0d exp=2/9", bar_of(bus_if.bar_height, 4), bar_of(bus_if.bar_height, 5)); end
        checks++; if (bus_if.peak_index !== 4'd5 || bus_if.peak_height !== 5'd9) begin errors++; $display("FAIL ovr_peak got=%0d/%0d exp=5/9", bus_if.peak_index, bus_if.peak_height); end
    endtask

    task automatic test_back_to_back();
        logic [SAMPLES_DEF*MAG_W_DEF-1:0] m;
        int n, n2;
        do_reset();
        m = '0; m[0 +: MAG_W_DEF] = 18'(6 << 13);
        bus_if.magnitudes = m; bus_if.done = 1'b1; bus_if.tick = 1'b1;
        step();
        bus_if.done = 1'b0; bus_if.tick = 1'b0;
        wait_uv(30, n);
        checks++; if (n !== 17) begin errors++; $display("FAIL b2b_scan_lat got=%0d exp=17", n); end
        checks++; if (bar_of(bus_if.bar_height, 0) !== 5'd6) begin errors++; $display("FAIL b2b_scan_h0 got=%0d exp=6", bar_of(bus_if.bar_height, 0)); end
        step();
        wait_uv(30, n2);
        checks++; if (bus_if.update_valid !== 1'b1 || n2 !== 17) begin errors++; $display("FAIL b2b_decay_lat got=%0d uv=%b exp=17 uv=1", n2, bus_if.update_valid); end
        checks++; if (bar_of(bus_if.bar_height, 0) !== 5'd6 || bus_if.peak_height !== 5'd6) begin errors++; $display("FAIL b2b_decay_hold got=%0d/%0d exp=6/6", bar_of(bus_if.bar_height, 0), bus_if.peak_height); end
        step();
    endtask

    task automatic test_reset_mid_scan();
        logic [SAMPLES_DEF*MAG_W_DEF-1:0] m;
        int pulses;
        m = '0; m[2*MAG_W_DEF +: MAG_W_DEF] = 18'(4 << 13);
        bus_if.magnitudes = m; bus_if.done = 1'b1; step(); bus_if.done = 1'b0;
        for (int k = 0; k < 7; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus_if.busy); end
        checks++; if (bus_if.bar_height !== '0 || bus_if.peak_height !== 5'd0 || bus_if.peak_index !== 4'd0) begin errors++; $display("FAIL midrst_outputs got=%h/%0d/%0d exp=0/0/0", bus_if.bar_height, bus_if.peak_height, bus_if.peak_index); end
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            if (bus_if.update_valid === 1'b1) pulses++;
            step();
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_pulse got=%0d exp=0", pulses); end
    endtask

    initial begin
        reset = 1'b0;
        bus_if.done = 1'b0;
        bus_if.tick = 1'b0;
        bus_if.magnitudes = '0;
        test_reset();
        test_single_bin();
        test_decay();
        test_saturate();
        test_overrun();
        test_back_to_back();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
